// File: rtl/sized_fifo_loopy_pkg.sv
// Shared constants and helpers for the sized_fifo_loopy slice.
package sized_fifo_loopy_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 4;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x * 2;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sized_fifo_loopy_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module sized_fifo_loopy_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  CLK,
   input  logic                  WE,
   input  logic [ADDR_WIDTH-1:0] WADDR,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic [ADDR_WIDTH-1:0] RADDR,
   output logic [DATA_WIDTH-1:0] RDATA
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (WE) mem[WADDR] <= WDATA;
   end

   assign RDATA = mem[RADDR];

endmodule

// File: rtl/sized_fifo_loopy.sv
// Sized FIFO whose FULL_N combinationally admits ENQ when DEQ frees a slot the same cycle.
module sized_fifo_loopy
   import sized_fifo_loopy_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int AFULL_LEVEL = DEPTH - 1,
   parameter int CNT_WIDTH   = clog2(DEPTH + 1)
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  ENQ,
   input  logic [DATA_WIDTH-1:0] D_IN,
   output logic                  FULL_N,
   input  logic                  DEQ,
   output logic [DATA_WIDTH-1:0] D_OUT,
   output logic                  EMPTY_N,
   input  logic                  CLR,
   output logic [CNT_WIDTH-1:0]  COUNT,
   output logic                  ALMOST_FULL
);

   localparam int                   PTR_WIDTH = clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] AFULL_C   = CNT_WIDTH'(AFULL_LEVEL);
   localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);

`ifdef BSV_NO_INITIAL_BLOCKS
   logic [PTR_WIDTH-1:0] head_r;
   logic [PTR_WIDTH-1:0] tail_r;
   logic [CNT_WIDTH-1:0] count_r;
   logic                 empty_n_r;
   logic                 afull_r;
`else
   logic [PTR_WIDTH-1:0] head_r    = '0;
   logic [PTR_WIDTH-1:0] tail_r    = '0;
   logic [CNT_WIDTH-1:0] count_r   = '0;
   logic                 empty_n_r = 1'b0;
   logic                 afull_r   = 1'b0;
`endif

   logic                 enq_ok;
   logic                 deq_ok;
   logic [CNT_WIDTH-1:0] count_nxt;
   logic [PTR_WIDTH-1:0] head_nxt;
   logic [PTR_WIDTH-1:0] tail_nxt;

   assign FULL_N      = (count_r != DEPTH_C) || DEQ;
   assign enq_ok      = ENQ && FULL_N && !CLR;
   assign deq_ok      = DEQ && empty_n_r && !CLR;
   assign EMPTY_N     = empty_n_r;
   assign COUNT       = count_r;
   assign ALMOST_FULL = afull_r;

   always_comb begin
      count_nxt = count_r;
      head_nxt  = head_r;
      tail_nxt  = tail_r;
      if (CLR) begin
         count_nxt = '0;
         head_nxt  = '0;
         tail_nxt  = '0;
      end else begin
         if (enq_ok && !deq_ok) count_nxt = count_r + CNT_WIDTH'(1);
         if (deq_ok && !enq_ok) count_nxt = count_r - CNT_WIDTH'(1);
         if (enq_ok) tail_nxt = (tail_r == LAST_PTR) ? '0 : tail_r + PTR_WIDTH'(1);
         if (deq_ok) head_nxt = (head_r == LAST_PTR) ? '0 : head_r + PTR_WIDTH'(1);
      end
   end

   // Flags are derived from next-state occupancy so all three agree every cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         head_r    <= '0;
         tail_r    <= '0;
         count_r   <= '0;
         empty_n_r <= 1'b0;
         afull_r   <= 1'b0;
      end else begin
         head_r    <= head_nxt;
         tail_r    <= tail_nxt;
         count_r   <= count_nxt;
         empty_n_r <= (count_nxt != '0);
         afull_r   <= (count_nxt >= AFULL_C);
      end
   end

   sized_fifo_loopy_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (PTR_WIDTH)
   ) u_ram (
      .CLK   (CLK),
      .WE    (enq_ok),
      .WADDR (tail_r),
      .WDATA (D_IN),
      .RADDR (head_r),
      .RDATA (D_OUT)
   );

`ifndef SYNTHESIS
   always_ff @(posedge CLK) begin
      if (RST_N && !CLR) begin
         if (ENQ && !FULL_N)
            $warning("%m: ENQ dropped while FIFO full");
         if (DEQ && !empty_n_r)
            $warning("%m: DEQ ignored while FIFO empty");
      end
   end
`endif

endmodule

// File: tb/tb_sized_fifo_loopy.sv
// Directed bench: a DEPTH=3/AFULL_LEVEL=2 instance and a default instance share stimulus.
module tb_sized_fifo_loopy;

   logic       CLK;
   logic       RST_N;
   logic       ENQ;
   logic       DEQ;
   logic       CLR;
   logic [7:0] D_IN;

   logic       d3_full_n, d3_empty_n, d3_afull;
   logic [7:0] d3_dout;
   logic [1:0] d3_count;

   logic       d4_full_n, d4_empty_n, d4_afull;
   logic [7:0] d4_dout;
   logic [2:0] d4_count;

   int checks;
   int failures;

   sized_fifo_loopy #(
      .DATA_WIDTH  (8),
      .DEPTH       (3),
      .AFULL_LEVEL (2)
   ) dut3 (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .ENQ         (ENQ),
      .D_IN        (D_IN),
      .FULL_N      (d3_full_n),
      .DEQ         (DEQ),
      .D_OUT       (d3_dout),
      .EMPTY_N     (d3_empty_n),
      .CLR         (CLR),
      .COUNT       (d3_count),
      .ALMOST_FULL (d3_afull)
   );

   sized_fifo_loopy dut4 (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .ENQ         (ENQ),
      .D_IN        (D_IN),
      .FULL_N      (d4_full_n),
      .DEQ         (DEQ),
      .D_OUT       (d4_dout),
      .EMPTY_N     (d4_empty_n),
      .CLR         (CLR),
      .COUNT       (d4_count),
      .ALMOST_FULL (d4_afull)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      RST_N = 1'b0;
      ENQ   = 1'b0;
      DEQ   = 1'b0;
      CLR   = 1'b0;
      D_IN  = 8'h00;
      #2;
      chk("rst_count",   32'(d3_count),   0);
      chk("rst_empty_n", 32'(d3_empty_n), 0);
      chk("rst_afull",   32'(d3_afull),   0);
      chk("rst_full_n",  32'(d3_full_n),  1);
      chk("rst_count4",  32'(d4_count),   0);
      step();
      step();
      RST_N = 1'b1;
      step();

      // In-order enqueue/dequeue of three entries
      ENQ = 1'b1; D_IN = 8'h11;
      step();
      chk("a_latency_dout", 32'(d3_dout),    32'h11);
      chk("a_latency_empn", 32'(d3_empty_n), 1);
      chk("a_count1",       32'(d3_count),   1);
      D_IN = 8'h22;
      step();
      D_IN = 8'h33;
      step();
      ENQ = 1'b0;
      #1;
      chk("a_d3_count3",  32'(d3_count),  3);
      chk("a_d3_full_n",  32'(d3_full_n), 0);
      chk("a_d3_afull",   32'(d3_afull),  1);
      chk("a_d4_count3",  32'(d4_count),  3);
      chk("a_d4_full_n",  32'(d4_full_n), 1);
      chk("a_d4_afull",   32'(d4_afull),  1);
      chk("a_head11",     32'(d4_dout),   32'h11);
      DEQ = 1'b1;
      step();
      chk("a_head22",  32'(d4_dout),  32'h22);
      chk("a_count2",  32'(d4_count), 2);
      step();
      chk("a_head33",  32'(d4_dout),  32'h33);
      chk("a_count1b", 32'(d4_count), 1);
      step();
      DEQ = 1'b0;
      chk("a_count0",  32'(d4_count),   0);
      chk("a_empty",   32'(d4_empty_n), 0);
      chk("a_afull0",  32'(d4_afull),   0);

      // Fill DEPTH=3 instance, then overflow ENQ is dropped
      ENQ = 1'b1; D_IN = 8'h01;
      step();
      D_IN = 8'h02;
      step();
      D_IN = 8'h03;
      step();
      chk("f_full_n", 32'(d3_full_n), 0);
      chk("f_afull",  32'(d3_afull),  1);
      D_IN = 8'h04;
      step();
      chk("f_drop_count", 32'(d3_count), 3);
      chk("f_drop_head",  32'(d3_dout),  32'h01);
      chk("f_d4_count4",  32'(d4_count), 4);
      chk("f_d4_full_n",  32'(d4_full_n), 0);

      // ENQ+DEQ on full: DEQ opens FULL_N in the same cycle
      DEQ = 1'b1;
      #1;
      chk("l_full_n_loopy", 32'(d3_full_n), 1);
      chk("l_d4_full_n",    32'(d4_full_n), 1);
      step();
      ENQ = 1'b0;
      chk("l_count",  32'(d3_count), 3);
      chk("l_head2",  32'(d3_dout),  32'h02);
      chk("l_d4_cnt", 32'(d4_count), 4);
      step();
      chk("l_head3",  32'(d3_dout),  32'h03);
      step();
      chk("l_head4",  32'(d3_dout),  32'h04);
      chk("l_d4_hd4", 32'(d4_dout),  32'h04);
      step();
      chk("l_drained", 32'(d3_empty_n), 0);
      chk("l_d4_cnt1", 32'(d4_count),   1);
      step();
      DEQ = 1'b0;
      chk("e_deq_empty_count", 32'(d3_count), 0);
      chk("e_d4_empty",        32'(d4_empty_n), 0);

      // One entry held, ENQ+DEQ together
      ENQ = 1'b1; D_IN = 8'hAA;
      step();
      D_IN = 8'hBB; DEQ = 1'b1;
      step();
      ENQ = 1'b0; DEQ = 1'b0;
      chk("s_dout",    32'(d3_dout),    32'hBB);
      chk("s_empty_n", 32'(d3_empty_n), 1);
      chk("s_count",   32'(d3_count),   1);

      // CLR wins over simultaneous ENQ+DEQ
      ENQ = 1'b1; D_IN = 8'hCC;
      step();
      chk("c_count2", 32'(d3_count), 2);
      CLR = 1'b1; D_IN = 8'hDD; DEQ = 1'b1;
      step();
      CLR = 1'b0; ENQ = 1'b0; DEQ = 1'b0;
      chk("c_count0", 32'(d3_count),   0);
      chk("c_empty",  32'(d3_empty_n), 0);
      chk("c_afull",  32'(d3_afull),   0);
      ENQ = 1'b1; D_IN = 8'h05;
      step();
      ENQ = 1'b0;
      chk("c_dout05", 32'(d3_dout),    32'h05);
      chk("c_cnt1",   32'(d3_count),   1);

      // Asynchronous reset between edges with three entries
      ENQ = 1'b1; D_IN = 8'h06;
      step();
      D_IN = 8'h07;
      step();
      ENQ = 1'b0;
      chk("r_pre_count", 32'(d3_count), 3);
      chk("r_pre_afull", 32'(d3_afull), 1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("r_async_count", 32'(d3_count),   0);
      chk("r_async_empty", 32'(d3_empty_n), 0);
      chk("r_async_afull", 32'(d3_afull),   0);
      chk("r_async_fulln", 32'(d3_full_n),  1);
      step();
      RST_N = 1'b1;
      step();
      ENQ = 1'b1; D_IN = 8'h09;
      step();
      ENQ = 1'b0;
      chk("r_post_dout",  32'(d3_dout),  32'h09);
      chk("r_post_count", 32'(d3_count), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
